// File: rtl/chan_cond_pkg.sv
// Shared definitions for the multi-channel input conditioner.
//
// Provides the per-channel output mode encoding and the output-mode
// selection function used by every lane. Mode codes are 2 bits wide and
// are applied per channel from the top-level mode bus.
package chan_cond_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_FALL   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  // Next value of a lane's output register.
  //   md      : output mode of the lane
  //   upd     : a new debounced level is accepted on this edge
  //   st_next : debounced level after this edge (equals the new level when upd)
  //   cur     : present output register value (TOGGLE keeps it as its base)
  function automatic logic next_out(mode_e md, logic upd, logic st_next, logic cur);
    logic r;
    r = st_next;
    case (md)
      MODE_LEVEL:  r = st_next;
      MODE_RISE:   r = upd & st_next;
      MODE_FALL:   r = upd & ~st_next;
      MODE_TOGGLE: r = cur ^ (upd & st_next);
      default:     r = st_next;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chan_cond_lane.sv
// One channel of the input conditioner: synchroniser, debounce filter and
// mode-selected output register.
//
// Ports
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset, clears all lane state
//   raw   in  1  raw asynchronous input
//   mode  in  2  output mode (LEVEL / RISE / FALL / TOGGLE)
//   out   out 1  conditioned output, registered
//   chg   out 1  one-cycle pulse on every accepted level change, registered
module chan_cond_lane
  import chan_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 4,
  parameter int CNT_W       = $clog2(DEB_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  logic [1:0] mode,
  output logic       out,
  output logic       chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;
  logic                   st_p1;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   upd;
  logic                   st_next;
  logic [CNT_W-1:0]       cnt_next;
  logic                   out_p2;
  logic                   chg_p2;

  // Stage 0: synchroniser chain, bit 0 samples the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p0[i] <= sync_p0[i-1];
      end
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage 1: debounce. cnt_p1 holds how many consecutive cycles the
  // synchronised level has differed from the stable level; the level is
  // accepted on the DEB_CYC-th such cycle. Any return to the stable level
  // discards the partial count.
  always_comb begin
    upd      = 1'b0;
    st_next  = st_p1;
    cnt_next = '0;
    if (s_p0 != st_p1) begin
      if (cnt_p1 == CNT_LAST) begin
        upd     = 1'b1;
        st_next = s_p0;
      end else begin
        cnt_next = cnt_p1 + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_p1  <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      st_p1  <= st_next;
      cnt_p1 <= cnt_next;
    end
  end

  // Stage 2: output register, driven from the acceptance decision of the
  // same edge so the mode outputs line up with chg.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p2 <= 1'b0;
      chg_p2 <= 1'b0;
    end else begin
      out_p2 <= next_out(mode_e'(mode), upd, st_next, out_p2);
      chg_p2 <= upd;
    end
  end

  assign out = out_p2;
  assign chg = chg_p2;

endmodule

// File: rtl/multi_chan_conditioner.sv
// Parametrised N-channel input conditioner for raw asynchronous inputs
// (buttons, external strobes). Each channel is synchronised, debounced and
// presented in its selected output mode; channels are fully independent.
//
// Parameters
//   NCH          number of channels (>= 1)
//   SYNC_STAGES  synchroniser flops per channel (>= 1)
//   DEB_CYC      consecutive differing cycles needed to accept a level (>= 1)
//
// Ports
//   clk     in  1      rising-edge clock
//   rst     in  1      synchronous active-high reset
//   in_ch   in  NCH    raw inputs, bit i = channel i
//   mode    in  2*NCH  per-channel mode, bits [2i+1:2i]
//   out_ch  out NCH    conditioned outputs, registered
//   chg     out NCH    per-channel accepted-change pulses, registered
module multi_chan_conditioner
  import chan_cond_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_ch,
  input  logic [2*NCH-1:0] mode,
  output logic [NCH-1:0]   out_ch,
  output logic [NCH-1:0]   chg
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    chan_cond_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYC    (DEB_CYC),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .raw (in_ch[i]),
      .mode(mode[2*i +: 2]),
      .out (out_ch[i]),
      .chg (chg[i])
    );
  end

endmodule
